// File: rtl/mux_arb_nbit_pkg.sv
// mux_pkg: shared constants for the arbitrating multiplexer.
//   MODE_RR / MODE_FIXED select the arbitration policy.
//   clog2() derives index widths from channel counts at elaboration.
package mux_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  // Width needed to encode n distinct indices (n >= 2 gives >= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_arb_nbit_rr_arbiter.sv
// rr_arbiter: purely combinational N-way arbiter.
//   req     in  NCH   request vector
//   last    in  SELW  most recent grant (round-robin pointer, ignored in fixed mode)
//   en      in  1     grants are issued only when high
//   gnt     out NCH   one-hot-or-zero grant
//   gnt_idx out SELW  encoded index of the winner (valid when gnt != 0)
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int MODE = MODE_RR,
  parameter int SELW = clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] last,
  input  logic            en,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] gnt_idx
);

  int              c;
  logic [SELW-1:0] ci;
  logic            found;

  // Walk the channels in search order and take the first requester.
  // Round-robin starts just after the last grant; fixed starts at 0.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    c       = 0;
    ci      = '0;
    for (int k = 0; k < NCH; k++) begin
      c  = (MODE == MODE_FIXED) ? k : (int'(last) + 1 + k) % NCH;
      ci = c[SELW-1:0];
      if (!found && req[ci]) begin
        found   = 1'b1;
        gnt_idx = ci;
        gnt[ci] = en;
      end
    end
  end

endmodule

// File: rtl/mux_arb_nbit.sv
// mux_arb_nbit: N-channel, W-bit arbitrating mux with a single-entry
// registered valid/ready output stage.
//   clk, rst_n          clock, synchronous active-low reset
//   in_data   in  NCH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid  in  NCH        channel offers a word
//   in_ready  out NCH        one-hot-or-zero grant (combinational)
//   out_data  out WIDTH      registered selected word
//   out_sel   out SELW       registered index of the supplying channel
//   out_valid out 1          output register holds a word
//   out_ready in  1          consumer takes out_data this edge
module mux_arb_nbit
  import mux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int MODE  = MODE_RR,
  localparam int SELW = clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [SELW-1:0]  last_q, last_d;

  logic             free;
  logic [NCH-1:0]   gnt;
  logic [SELW-1:0]  gnt_idx;
  logic             accept;
  logic [WIDTH-1:0] sel_word;

  // Register can take a word if empty or being drained this edge.
  // Gating with rst_n keeps grants low throughout reset.
  assign free = !valid_q || out_ready;

  rr_arbiter #(.NCH(NCH), .MODE(MODE), .SELW(SELW)) u_arb (
    .req     (in_valid),
    .last    (last_q),
    .en      (free && rst_n),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign in_ready = gnt;
  assign accept   = |gnt;

  // AND-OR word select over the one-hot grant.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NCH; i++)
      sel_word = sel_word | (in_data[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}});
  end

  always_comb begin
    data_d  = data_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (accept) begin
      data_d  = sel_word;
      sel_d   = gnt_idx;
      valid_d = 1'b1;
      if (MODE == MODE_RR) last_d = gnt_idx;
    end else if (free) begin
      // Drain with no refill: data/sel keep their last values.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= SELW'(NCH - 1);   // channel 0 first after reset
    end else begin
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_arb_nbit.sv
module tb_mux_arb_nbit;
  import mux_pkg::*;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic           out_ready;

  // index 0: round-robin instance, index 1: fixed-priority instance
  logic [N-1:0]  rdy [2];
  logic [W-1:0]  od  [2];
  logic [SW-1:0] os  [2];
  logic          ov  [2];

  always #5 clk = ~clk;

  mux_arb_nbit #(.WIDTH(W), .NCH(N), .MODE(MODE_RR)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[0]), .out_data(od[0]), .out_sel(os[0]), .out_valid(ov[0]),
    .out_ready(out_ready));

  mux_arb_nbit #(.WIDTH(W), .NCH(N), .MODE(MODE_FIXED)) u_fx (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[1]), .out_data(od[1]), .out_sel(os[1]), .out_valid(ov[1]),
    .out_ready(out_ready));

  int nvec = 0;
  int nerr = 0;

  // Reference model state per instance
  logic         m_ov   [2] = '{1'b0, 1'b0};
  logic [W-1:0] m_od   [2] = '{16'h0, 16'h0};
  int           m_os   [2] = '{0, 0};
  int           m_last [2] = '{N-1, N-1};
  logic [N-1:0] rdy_s  [2];

  // Winner by rule: fixed = lowest valid index; rr = first valid after last.
  function automatic int pick(input int mode, input int last, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (mode == 1) ? k : (last + 1 + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s (inst %0d) at %0t: got %h expected %h", nm, m, $time, act, exp);
    end
  endtask

  // One clock: drive inputs, check grants pre-edge, advance model, check outputs post-edge.
  task automatic step(input logic r, input logic [N-1:0] v, input logic o);
    int g [2];
    rst_n = r; in_valid = v; out_ready = o;
    #2;
    for (int m = 0; m < 2; m++) begin
      logic [N-1:0] e;
      g[m] = pick(m, m_last[m], v);
      e = (r && (!m_ov[m] || o) && g[m] >= 0) ? N'(1 << g[m]) : '0;
      rdy_s[m] = rdy[m];
      chk("in_ready", m, 32'(rdy[m]), 32'(e));
      if (e == '0) g[m] = -1;
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (!r) begin
        m_ov[m] = 1'b0; m_od[m] = '0; m_os[m] = 0; m_last[m] = N - 1;
      end else if (g[m] >= 0) begin
        m_ov[m] = 1'b1; m_od[m] = in_data[g[m]*W +: W]; m_os[m] = g[m];
        if (m == 0) m_last[m] = g[m];
      end else if (!m_ov[m] || o) begin
        m_ov[m] = 1'b0;
      end
    end
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("out_valid", m, 32'(ov[m]), 32'(m_ov[m]));
      chk("out_sel",   m, 32'(os[m]), 32'(m_os[m]));
      chk("out_data",  m, 32'(od[m]), 32'(m_od[m]));
    end
  endtask

  typedef struct {
    logic         r;
    logic [N-1:0] v;
    logic         o;
    logic [N-1:0] e_rdy;
    logic         e_ov;
    logic [SW-1:0] e_sel;
    logic [W-1:0] e_dat;
  } vec_t;

  vec_t tv[$];

  function automatic void add(logic r, logic [N-1:0] v, logic o, logic [N-1:0] er,
                              logic eov, logic [SW-1:0] es, logic [W-1:0] ed);
    vec_t t;
    t.r = r; t.v = v; t.o = o; t.e_rdy = er; t.e_ov = eov; t.e_sel = es; t.e_dat = ed;
    tv.push_back(t);
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = '0; out_ready = 1'b0;
    in_data = {16'hA003, 16'hA002, 16'hA001, 16'hA000};

    // Round-robin directed table (checks instance 0 against hand values)
    add(0, 4'hF, 1, 4'b0000, 0, 0, 16'h0000);
    add(0, 4'hF, 1, 4'b0000, 0, 0, 16'h0000);
    add(1, 4'hF, 1, 4'b0001, 1, 0, 16'hA000);
    add(1, 4'hF, 1, 4'b0010, 1, 1, 16'hA001);
    add(1, 4'hF, 1, 4'b0100, 1, 2, 16'hA002);
    add(1, 4'hF, 1, 4'b1000, 1, 3, 16'hA003);
    add(1, 4'hF, 1, 4'b0001, 1, 0, 16'hA000);
    add(1, 4'hF, 1, 4'b0010, 1, 1, 16'hA001);
    add(1, 4'hF, 1, 4'b0100, 1, 2, 16'hA002);
    add(1, 4'hF, 1, 4'b1000, 1, 3, 16'hA003);
    for (int i = 0; i < 5; i++) add(1, 4'b0100, 0, 4'b0000, 1, 3, 16'hA003);
    add(1, 4'b0100, 1, 4'b0100, 1, 2, 16'hA002);
    add(1, 4'b1000, 1, 4'b1000, 1, 3, 16'hA003);
    add(1, 4'b1010, 1, 4'b0010, 1, 1, 16'hA001);
    add(1, 4'b0000, 1, 4'b0000, 0, 1, 16'hA001);
    add(1, 4'b0000, 1, 4'b0000, 0, 1, 16'hA001);
    add(1, 4'b0100, 1, 4'b0100, 1, 2, 16'hA002);
    add(1, 4'b0100, 0, 4'b0000, 1, 2, 16'hA002);
    add(0, 4'b0100, 0, 4'b0000, 0, 0, 16'h0000);
    add(1, 4'hF, 1, 4'b0001, 1, 0, 16'hA000);

    foreach (tv[i]) begin
      step(tv[i].r, tv[i].v, tv[i].o);
      chk("tbl_in_ready",  0, 32'(rdy_s[0]), 32'(tv[i].e_rdy));
      chk("tbl_out_valid", 0, 32'(ov[0]),    32'(tv[i].e_ov));
      chk("tbl_out_sel",   0, 32'(os[0]),    32'(tv[i].e_sel));
      chk("tbl_out_data",  0, 32'(od[0]),    32'(tv[i].e_dat));
    end

    // Fixed priority: ch1 beats ch3 until ch1 drops
    step(0, 4'b0000, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 4'b1010, 1);
      chk("fx_in_ready", 1, 32'(rdy_s[1]), 32'(4'b0010));
      chk("fx_out_sel",  1, 32'(os[1]),    32'd1);
    end
    step(1, 4'b1000, 1);
    chk("fx_in_ready", 1, 32'(rdy_s[1]), 32'(4'b1000));
    chk("fx_out_sel",  1, 32'(os[1]),    32'd3);
    chk("fx_out_data", 1, 32'(od[1]),    32'hA003);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_data = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      step(($urandom_range(0, 40) != 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
